// File: rtl/gal_olmc_bank.sv
// ---------------------------------------------------------------------------
// gal_olmc_bank
//
// Bank of N GAL output logic macrocells (OLMCs). Each channel is fixed at
// elaboration to either registered or combinational mode, and to true or
// inverted output polarity. Registered channels share a synchronous reset
// (R) and a synchronous preset (SP); reset has priority over preset.
//
// Parameters:
//   N          - number of macrocells, 1..10
//   REGISTERED - per-channel mode mask (1 = registered, 0 = combinational)
//   INVERTED   - per-channel polarity mask (1 = active-low output)
//
// Ports:
//   C    - clock, rising edge
//   R    - synchronous reset, active-high, clears every register
//   SP   - synchronous preset, active-high, sets every register
//   A    - sum-term inputs from the AND/OR array, one per channel
//   E    - product-term output enables, one per channel
//   Y    - macrocell output value at the pin, before the tristate
//   Y_OE - pin drive enable (Y must be treated as high-Z when low)
//   FB   - feedback into the AND array
// ---------------------------------------------------------------------------
module gal_olmc_bank #(
    parameter int           N          = 8,
    parameter logic [N-1:0] REGISTERED = {N{1'b1}},
    parameter logic [N-1:0] INVERTED   = {N{1'b0}}
) (
    input  logic         C,
    input  logic         R,
    input  logic         SP,
    input  logic [N-1:0] A,
    input  logic [N-1:0] E,
    output logic [N-1:0] Y,
    output logic [N-1:0] Y_OE,
    output logic [N-1:0] FB
);

    // The enable is a pure product term; it is never registered and does
    // not gate the computed value on Y.
    assign Y_OE = E;

    generate
        if (N < 1 || N > 10) begin : g_bad_n
            $error("gal_olmc_bank: N=%0d is outside the supported range 1..10", N);
        end

        for (genvar gi = 0; gi < N; gi++) begin : g_cell
            if (REGISTERED[gi]) begin : g_reg
                logic q_reg;

                always_ff @(posedge C) begin
                    if (R) begin
                        q_reg <= 1'b0;
                    end else if (SP) begin
                        q_reg <= 1'b1;
                    end else begin
                        q_reg <= A[gi];
                    end
                end

                // Feedback taps the true register value, ahead of the
                // polarity XOR, so the array always sees Q regardless of
                // how the pin is configured.
                assign Y[gi]  = q_reg ^ INVERTED[gi];
                assign FB[gi] = q_reg;
            end else begin : g_comb
                // Combinational cells have no storage; feedback is the
                // pin value itself, including the polarity XOR.
                assign Y[gi]  = A[gi] ^ INVERTED[gi];
                assign FB[gi] = A[gi] ^ INVERTED[gi];
            end
        end
    endgenerate

endmodule

// File: tb/tb_gal_olmc_bank.sv
// ---------------------------------------------------------------------------
// tb_gal_olmc_bank
//
// Self-checking bench for gal_olmc_bank with N = 4, REGISTERED = 4'b0011,
// INVERTED = 4'b0101. A behavioural model holds the register contents as a
// plain vector and derives every expected output from the mode/polarity
// masks. Directed steps follow the test plan, then a randomized run.
// ---------------------------------------------------------------------------
module tb_gal_olmc_bank;

    localparam int         N     = 4;
    localparam logic [3:0] REGM  = 4'b0011;
    localparam logic [3:0] INVM  = 4'b0101;

    logic       C;
    logic       R;
    logic       SP;
    logic [3:0] A;
    logic [3:0] E;
    logic [3:0] Y;
    logic [3:0] Y_OE;
    logic [3:0] FB;

    int n_checks;
    int n_fail;

    // Model state: stored bits of the registered channels (others unused).
    logic [3:0] model_q;

    gal_olmc_bank #(
        .N          (N),
        .REGISTERED (REGM),
        .INVERTED   (INVM)
    ) dut (
        .C    (C),
        .R    (R),
        .SP   (SP),
        .A    (A),
        .E    (E),
        .Y    (Y),
        .Y_OE (Y_OE),
        .FB   (FB)
    );

    initial C = 1'b0;
    always #5 C = ~C;

    function automatic logic [3:0] exp_y(input logic [3:0] q, input logic [3:0] a);
        logic [3:0] r;
        for (int i = 0; i < 4; i++)
            r[i] = REGM[i] ? (q[i] ^ INVM[i]) : (a[i] ^ INVM[i]);
        return r;
    endfunction

    function automatic logic [3:0] exp_fb(input logic [3:0] q, input logic [3:0] a);
        logic [3:0] r;
        for (int i = 0; i < 4; i++)
            r[i] = REGM[i] ? q[i] : (a[i] ^ INVM[i]);
        return r;
    endfunction

    task automatic check_eq(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".Y"},    Y,    exp_y(model_q, A));
        check_eq({tag, ".FB"},   FB,   exp_fb(model_q, A));
        check_eq({tag, ".Y_OE"}, Y_OE, E);
        $display("txn %-14s R=%b SP=%b A=%b E=%b -> Y=%b FB=%b Y_OE=%b",
                 tag, R, SP, A, E, Y, FB, Y_OE);
    endtask

    // One cycle: drive on the falling edge, check zero-latency paths before
    // the rising edge, advance the model at the edge, check again after.
    task automatic step(input string tag, input logic r, input logic sp,
                        input logic [3:0] a, input logic [3:0] e);
        @(negedge C);
        R = r; SP = sp; A = a; E = e;
        #1;
        check_all({tag, ".pre"});
        @(posedge C);
        if (r)       model_q = 4'b0000;
        else if (sp) model_q = 4'b1111;
        else         model_q = a;
        #1;
        check_all({tag, ".post"});
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        R = 1'b1; SP = 1'b0; A = 4'b1111; E = 4'b0000;
        model_q = 4'b0000;

        // 1. Reset: first edge with R = 1, no checks before it.
        @(posedge C);
        #1;
        check_all("reset");
        check_eq("reset.Y10",  Y[1:0],  2'b01);
        check_eq("reset.FB10", FB[1:0], 2'b00);
        check_eq("reset.Y32",  Y[3:2],  2'b10);
        check_eq("reset.FB32", FB[3:2], 2'b10);

        // 2. Registered latency.
        step("latency", 1'b0, 1'b0, 4'b0010, 4'b0000);
        check_eq("latency.Y10",  Y[1:0],  2'b11);
        check_eq("latency.FB10", FB[1:0], 2'b10);

        // 3. Preset, then reset/preset priority.
        step("preset", 1'b0, 1'b1, 4'b0000, 4'b0000);
        check_eq("preset.FB10", FB[1:0], 2'b11);
        check_eq("preset.Y10",  Y[1:0],  2'b10);
        step("prio", 1'b1, 1'b1, 4'b1111, 4'b0000);
        check_eq("prio.FB10", FB[1:0], 2'b00);

        // 4. Preset hold with A toggling, then release.
        step("hold0", 1'b0, 1'b1, 4'b0000, 4'b0000);
        step("hold1", 1'b0, 1'b1, 4'b1111, 4'b0000);
        step("hold2", 1'b0, 1'b1, 4'b0101, 4'b0000);
        check_eq("hold.FB10", FB[1:0], 2'b11);
        step("release", 1'b0, 1'b0, 4'b0000, 4'b0000);
        check_eq("release.FB10", FB[1:0], 2'b00);

        // 5. Output enable does not disturb values or state.
        step("oe_load", 1'b0, 1'b0, 4'b0110, 4'b1010);
        check_eq("oe.Y_OE", Y_OE, 4'b1010);
        step("oe_flip", 1'b0, 1'b0, 4'b1001, 4'b0101);
        check_eq("oe.FB10", FB[1:0], 2'b01);

        // 6. Combinational isolation across R/SP pulses.
        for (int v = 0; v < 4; v++) begin
            step("comb_r",  1'b1, 1'b0, {v[1:0], 2'b10}, 4'b1111);
            check_eq("comb_r.Y32",  Y[3:2], v[1:0] ^ 2'b01);
            step("comb_sp", 1'b0, 1'b1, {v[1:0], 2'b01}, 4'b0000);
            check_eq("comb_sp.FB32", FB[3:2], Y[3:2]);
        end

        // Randomized run against the model.
        for (int k = 0; k < 60; k++) begin
            step("random",
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 5) == 0),
                 4'($urandom), 4'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gal_olmc_bank.md
# gal_olmc_bank

Parametrised bank of N GAL output logic macrocells, each set at elaboration to registered or combinational mode and to inverted or true polarity. It extends the single-cell OLMC with three things: a shared synchronous reset, a shared synchronous preset, and a per-channel output enable, plus a per-channel feedback tap back into the AND array. The techmap instantiates one bank per device output group, and simulation uses it as the behavioural model for the whole output stage of a GAL16V8/22V10-class target.

## Interface
- N, default 8: number of macrocells (1..10).
- REGISTERED, default {N{1'b1}}: per-channel mode mask; bit i = 1 means registered, 0 means combinational.
- INVERTED, default {N{1'b0}}: per-channel polarity mask; bit i = 1 means the output is active-low (inverted).
- C, input, 1: the only clock. Registers update on the rising edge.
- R, input, 1: reset, synchronous and active-high. It clears every register.
- SP, input, 1: synchronous preset, active-high. It sets every register.
- A, input, N: sum-term inputs from the AND/OR array, one per channel.
- E, input, N: product-term output enables, one per channel.
- Y, output, N: macrocell output value at the pin, before the tristate.
- Y_OE, output, N: effective pin drive enable.
- FB, output, N: feedback into the AND array.

## Operation
- Each channel has one storage bit Q[i]. Registers are only instantiated where REGISTERED[i] = 1. Combinational channels contain no flops.
- Registered channel, on each rising edge of C, with priority from highest to lowest:
  - R = 1: Q[i] <= 0.
  - else SP = 1: Q[i] <= 1.
  - else: Q[i] <= A[i].
- Registered channel outputs:
  - Y[i] = Q[i] ^ INVERTED[i].
  - FB[i] = Q[i], the true register value, independent of polarity.
- Combinational channel outputs:
  - Y[i] = A[i] ^ INVERTED[i].
  - FB[i] = Y[i], i.e. the pin value.
  - R and SP have no effect on combinational channels.
- Output enable:
  - Y_OE[i] = E[i] for every channel, in both modes.
  - The value on Y is always computed, whether or not Y_OE is high. Consumers must treat Y as high-Z when Y_OE is low.
- Validity of masks:
  - REGISTERED and INVERTED must be exactly N bits wide.
  - N outside 1..10 is an elaboration error, raised via a generate-time $error.

## Timing
- Registered path: A sampled at edge k appears on Y and FB after edge k, giving 1-cycle latency.
- Combinational path: A to Y and FB with zero cycle latency.
- E to Y_OE: zero cycle latency in both modes. E is never registered.
- Reset values, after the first edge with R = 1:
  - registered channel: Q = 0, FB = 0, Y = INVERTED[i].
  - combinational channel: follows A with no change.
- Before the first reset or clock edge, registered Q is X. The bench must not check any output before reset.
- R and SP high on the same edge: reset wins and Q = 0.
- SP held high for several cycles: Q stays 1 and A is ignored. On the first edge after SP drops, Q takes A.
- R asserted mid-stream: the edge with R = 1 discards the value of A at that edge. On the next edge without R or SP, Q takes A.
- No clock enable. Every edge with R = 0 and SP = 0 loads A.

## Test plan
All scenarios use N = 4, REGISTERED = 4'b0011, INVERTED = 4'b0101.

1. Reset:
   - Stimulus: R = 1 for one edge, A = 4'b1111, SP = 0.
   - Required: Q[1:0] = 0, Y[1:0] = 2'b01, FB[1:0] = 2'b00.
   - Required: Y[3:2] = 2'b10 with zero latency, FB[3:2] = 2'b10.
2. Registered latency:
   - Stimulus: after reset, A = 4'b0010 at edge k.
   - Required: Y[1:0] stays 2'b01 until edge k, then becomes 2'b11 after edge k.
   - Required: FB[1:0] = 2'b10.
3. Preset and priority:
   - Stimulus: SP = 1 for one edge.
   - Required: Q[1:0] = 2'b11 and Y[1:0] = 2'b10.
   - Stimulus: R = 1 and SP = 1 on the same edge.
   - Required: Q[1:0] = 2'b00.
4. Preset hold and release:
   - Stimulus: SP = 1 for 3 edges with A toggling, then SP = 0 with A = 4'b0000.
   - Required: Q[1:0] = 2'b11 during the hold.
   - Required: Q[1:0] = 2'b00 one edge after SP drops.
5. Output enable:
   - Stimulus: E = 4'b1010 with arbitrary A.
   - Required: Y_OE = 4'b1010 in the same cycle.
   - Required: Y values are unchanged by E, and registered state is unaffected.
6. Combinational isolation:
   - Stimulus: drive A[3:2] through all 4 values while R or SP is pulsed.
   - Required: Y[3:2] = A[3:2] ^ 2'b01 at every sample.
   - Required: FB[3:2] equals Y[3:2].
